// File: rtl/arb_rsp_router_pkg.sv
// Shared width helpers for the arbiter response router slice.
package arb_rsp_router_pkg;

  // Requester-index width; a single requester still needs one bit.
  function automatic int calc_idx_width(input int num_in);
    return (num_in > 32'sd1) ? $clog2(num_in) : 32'sd1;
  endfunction

  // Counter width able to hold 0..depth inclusive.
  function automatic int calc_cnt_width(input int depth);
    return $clog2(depth) + 32'sd1;
  endfunction

endpackage

// File: rtl/arb_rsp_router_if.sv
// Arbiter-side, memory-side and response signals of the router.
// master = router view, slave = surrounding logic view.
interface arb_rsp_router_if
  import arb_rsp_router_pkg::*;
#(
  parameter int NumIn     = 4,
  parameter int DataWidth = 32
);
  localparam int IdxWidth = calc_idx_width(NumIn);

  logic                 arb_req_i;
  logic [IdxWidth-1:0]  arb_idx_i;
  logic                 arb_gnt_o;
  logic                 mem_req_o;
  logic                 mem_gnt_i;
  logic                 mem_rvalid_i;
  logic [DataWidth-1:0] mem_rdata_i;
  logic [NumIn-1:0]     rsp_valid_o;
  logic [DataWidth-1:0] rsp_data_o;

  modport master (
    input  arb_req_i, arb_idx_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output arb_gnt_o, mem_req_o, rsp_valid_o, rsp_data_o
  );

  modport slave (
    output arb_req_i, arb_idx_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  arb_gnt_o, mem_req_o, rsp_valid_o, rsp_data_o
  );

endinterface

// File: rtl/arb_idx_fifo.sv
// In-order tracking queue of granted requester indices. Registered head,
// no fall-through: a pushed entry is visible at the head one cycle later.
module arb_idx_fifo #(
  parameter  int Width    = 2,
  parameter  int Depth    = 4,
  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int CntWidth = $clog2(Depth) + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                push_i,
  input  logic [Width-1:0]    data_i,
  input  logic                pop_i,
  output logic                full_o,
  output logic                empty_o,
  output logic [CntWidth-1:0] count_o,
  output logic [Width-1:0]    head_o
);

  logic [Width-1:0]    mem_r [Depth];
  logic [PtrWidth-1:0] wr_ptr_r;
  logic [PtrWidth-1:0] rd_ptr_r;
  logic [CntWidth-1:0] count_r;
  logic [CntWidth-1:0] count_d_s;
  logic                full_s;
  logic                empty_s;
  logic                push_s;
  logic                pop_s;

  // Pointer advance with explicit wrap so non-power-of-two depths stay safe.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
    if (ptr == PtrWidth'(Depth - 1)) begin
      return {PtrWidth{1'b0}};
    end else begin
      return ptr + PtrWidth'(1'b1);
    end
  endfunction

  assign full_s  = (count_r == CntWidth'(Depth));
  assign empty_s = (count_r == {CntWidth{1'b0}});
  assign push_s  = push_i & ~full_s;
  assign pop_s   = pop_i & ~empty_s;

  // Occupancy update: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_d_s = count_r + CntWidth'(1'b1);
      2'b01:   count_d_s = count_r - CntWidth'(1'b1);
      default: count_d_s = count_r;
    endcase
  end

  // Pointer and count state; flush discards any push/pop of that cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_r <= {PtrWidth{1'b0}};
      rd_ptr_r <= {PtrWidth{1'b0}};
      count_r  <= {CntWidth{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_d_s;
    end
  end

  // Entry storage; contents are only meaningful while counted.
  always_ff @(posedge clk_i) begin
    if (push_s && !flush_i && !rst_i) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

  assign full_o  = full_s;
  assign empty_o = empty_s;
  assign count_o = count_r;
  assign head_o  = mem_r[rd_ptr_r];

endmodule

// File: rtl/arb_rsp_router.sv
// Forwards arbiter winners to memory, remembers who won in issue order and
// steers each returning response back to that requester one cycle later.
module arb_rsp_router
  import arb_rsp_router_pkg::*;
#(
  parameter  int NumIn          = 4,
  parameter  int DataWidth      = 32,
  parameter  int MaxOutstanding = 4,
  localparam int IdxWidth       = calc_idx_width(NumIn),
  localparam int CntWidth       = calc_cnt_width(MaxOutstanding)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  arb_rsp_router_if.master    bus,
  output logic [CntWidth-1:0] outstanding_o,
  output logic                rsp_err_o
);

  logic                 full_s;
  logic                 empty_s;
  logic                 push_s;
  logic                 pop_s;
  logic [CntWidth-1:0]  count_s;
  logic [IdxWidth-1:0]  head_s;
  logic [NumIn-1:0]     onehot_s;
  logic [NumIn-1:0]     rsp_valid_r;
  logic [DataWidth-1:0] rsp_data_r;
  logic                 rsp_err_r;

  // Full comes from registered occupancy only, so a same-cycle pop never
  // reopens the request path.
  assign bus.mem_req_o = bus.arb_req_i & ~full_s;
  assign bus.arb_gnt_o = bus.mem_gnt_i & ~full_s;
  assign push_s        = bus.mem_req_o & bus.mem_gnt_i;
  assign pop_s         = bus.mem_rvalid_i & ~empty_s;

  arb_idx_fifo #(
    .Width (IdxWidth),
    .Depth (MaxOutstanding)
  ) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push_s),
    .data_i  (bus.arb_idx_i),
    .pop_i   (pop_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s),
    .head_o  (head_s)
  );

  // Decode the head index into a per-requester valid vector.
  always_comb begin
    onehot_s = {NumIn{1'b0}};
    for (int i = 0; i < NumIn; i++) begin
      if (head_s == IdxWidth'(i)) begin
        onehot_s[i] = 1'b1;
      end else begin
        onehot_s[i] = 1'b0;
      end
    end
  end

  // Response stage: one cycle after a pop, plus the unexpected-response pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_r <= {NumIn{1'b0}};
      rsp_data_r  <= {DataWidth{1'b0}};
      rsp_err_r   <= 1'b0;
    end else if (flush_i) begin
      rsp_valid_r <= {NumIn{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= pop_s ? onehot_s : {NumIn{1'b0}};
      if (pop_s) begin
        rsp_data_r <= bus.mem_rdata_i;
      end
      rsp_err_r <= bus.mem_rvalid_i & empty_s;
    end
  end

  assign bus.rsp_valid_o = rsp_valid_r;
  assign bus.rsp_data_o  = rsp_data_r;
  assign rsp_err_o       = rsp_err_r;
  assign outstanding_o   = count_s;

endmodule

// File: tb/tb_arb_rsp_router.sv
// Self-checking bench for arb_rsp_router (NumIn=4, DataWidth=32, depth 4).
module tb_arb_rsp_router;

  localparam int NumIn  = 4;
  localparam int DW     = 32;
  localparam int MaxOut = 4;

  typedef struct {
    logic [NumIn-1:0] valid;
    logic [DW-1:0]    data;
    logic             err;
    int               outst;
  } exp_t;

  logic clk;
  logic rst;
  logic flush;
  logic [2:0] outstanding;
  logic rsp_err;

  int n_vec;
  int n_err;

  exp_t       exp_q[$];
  logic [1:0] model_q[$];
  logic [DW-1:0] last_data;
  exp_t       mon_e;

  arb_rsp_router_if #(.NumIn(NumIn), .DataWidth(DW)) bus_if ();

  arb_rsp_router #(
    .NumIn          (NumIn),
    .DataWidth      (DW),
    .MaxOutstanding (MaxOut)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .bus           (bus_if),
    .outstanding_o (outstanding),
    .rsp_err_o     (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: compares registered outputs shortly after each edge.
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_vec++;
      if (bus_if.rsp_valid_o !== mon_e.valid) begin
        n_err++;
        $display("FAIL sb_rsp_valid got %b exp %b at %0t", bus_if.rsp_valid_o, mon_e.valid, $time);
      end
      n_vec++;
      if (bus_if.rsp_data_o !== mon_e.data) begin
        n_err++;
        $display("FAIL sb_rsp_data got %h exp %h at %0t", bus_if.rsp_data_o, mon_e.data, $time);
      end
      n_vec++;
      if (rsp_err !== mon_e.err) begin
        n_err++;
        $display("FAIL sb_rsp_err got %b exp %b at %0t", rsp_err, mon_e.err, $time);
      end
      n_vec++;
      if (int'(outstanding) != mon_e.outst) begin
        n_err++;
        $display("FAIL sb_outstanding got %0d exp %0d at %0t", outstanding, mon_e.outst, $time);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Drive one cycle of stimulus (called at negedge) and queue the expectation.
  task automatic apply(input logic req, input logic [1:0] idx, input logic gnt,
                       input logic rv, input logic [DW-1:0] data, input logic fl);
    exp_t e;
    logic full, push, pop, err;
    logic [1:0] head;
    bus_if.arb_req_i    = req;
    bus_if.arb_idx_i    = idx;
    bus_if.mem_gnt_i    = gnt;
    bus_if.mem_rvalid_i = rv;
    bus_if.mem_rdata_i  = data;
    flush               = fl;
    full = (model_q.size() == MaxOut);
    push = req && gnt && !full && !fl;
    pop  = rv && (model_q.size() != 0) && !fl;
    err  = rv && (model_q.size() == 0) && !fl;
    e.valid = '0;
    if (pop) begin
      head = model_q.pop_front();
      e.valid[head] = 1'b1;
      last_data = data;
    end
    if (fl) model_q.delete();
    if (push) model_q.push_back(idx);
    e.data  = last_data;
    e.err   = err;
    e.outst = model_q.size();
    exp_q.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    bus_if.arb_req_i = 1'b0; bus_if.arb_idx_i = 2'd0; bus_if.mem_gnt_i = 1'b0;
    bus_if.mem_rvalid_i = 1'b0; bus_if.mem_rdata_i = 32'h0;
    model_q.delete();
    last_data = 32'h0;
    repeat (3) tick();
    rst = 1'b0;
    n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
    n_vec++; if (bus_if.rsp_valid_o !== 4'b0000) begin n_err++; $display("FAIL reset_rsp_valid got %b exp 0000", bus_if.rsp_valid_o); end
    n_vec++; if (bus_if.rsp_data_o !== 32'h0) begin n_err++; $display("FAIL reset_rsp_data got %h exp 0", bus_if.rsp_data_o); end
    n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
    apply(1'b0, 2'd0, 1'b1, 1'b0, 32'h0, 1'b0);
    n_vec++; if (bus_if.arb_gnt_o !== 1'b1) begin n_err++; $display("FAIL idle_gnt_follow got %b exp 1", bus_if.arb_gnt_o); end
    n_vec++; if (bus_if.mem_req_o !== 1'b0) begin n_err++; $display("FAIL idle_mem_req got %b exp 0", bus_if.mem_req_o); end
    tick();
    apply(1'b1, 2'd1, 1'b0, 1'b0, 32'h0, 1'b0);
    n_vec++; if (bus_if.arb_gnt_o !== 1'b0) begin n_err++; $display("FAIL idle_gnt_low got %b exp 0", bus_if.arb_gnt_o); end
    n_vec++; if (bus_if.mem_req_o !== 1'b1) begin n_err++; $display("FAIL idle_mem_req_hi got %b exp 1", bus_if.mem_req_o); end
    tick();
    n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL idle_no_push got %0d exp 0", outstanding); end
  endtask

  task automatic test_routing();
    logic [1:0] idxs [3];
    logic [DW-1:0] dat [3];
    logic [3:0] oh [3];
    idxs[0] = 2'd2; idxs[1] = 2'd0; idxs[2] = 2'd3;
    dat[0] = 32'hAAAA_0001; dat[1] = 32'hBBBB_0002; dat[2] = 32'hCCCC_0003;
    oh[0] = 4'b0100; oh[1] = 4'b0001; oh[2] = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, idxs[i], 1'b1, 1'b0, 32'h0, 1'b0);
      tick();
    end
    n_vec++; if (outstanding !== 3'd3) begin n_err++; $display("FAIL route_outstanding got %0d exp 3", outstanding); end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 2'd0, 1'b0, 1'b1, dat[i], 1'b0);
      tick();
      n_vec++; if (bus_if.rsp_valid_o !== oh[i]) begin n_err++; $display("FAIL route_valid%0d got %b exp %b", i, bus_if.rsp_valid_o, oh[i]); end
      n_vec++; if (bus_if.rsp_data_o !== dat[i]) begin n_err++; $display("FAIL route_data%0d got %h exp %h", i, bus_if.rsp_data_o, dat[i]); end
    end
    apply(1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    n_vec++; if (bus_if.rsp_valid_o !== 4'b0000) begin n_err++; $display("FAIL route_valid_drop got %b exp 0000", bus_if.rsp_valid_o); end
    n_vec++; if (bus_if.rsp_data_o !== 32'hCCCC_0003) begin n_err++; $display("FAIL route_data_hold got %h exp cccc0003", bus_if.rsp_data_o); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 2'($urandom_range(3, 0)), 1'b1, 1'b0, 32'h0, 1'b0);
      if (i == 4) begin
        n_vec++; if (bus_if.arb_gnt_o !== 1'b0) begin n_err++; $display("FAIL fill_gnt_blocked got %b exp 0", bus_if.arb_gnt_o); end
        n_vec++; if (bus_if.mem_req_o !== 1'b0) begin n_err++; $display("FAIL fill_req_blocked got %b exp 0", bus_if.mem_req_o); end
      end
      tick();
    end
    n_vec++; if (outstanding !== 3'd4) begin n_err++; $display("FAIL fill_outstanding got %0d exp 4", outstanding); end
  endtask

  task automatic test_full_pop_and_wrap();
    apply(1'b1, 2'd1, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
    n_vec++; if (bus_if.mem_req_o !== 1'b0) begin n_err++; $display("FAIL fullpop_req got %b exp 0", bus_if.mem_req_o); end
    tick();
    n_vec++; if (outstanding !== 3'd3) begin n_err++; $display("FAIL fullpop_outstanding got %0d exp 3", outstanding); end
    apply(1'b1, 2'd1, 1'b1, 1'b0, 32'h0, 1'b0);
    n_vec++; if (bus_if.arb_gnt_o !== 1'b1) begin n_err++; $display("FAIL refill_gnt got %b exp 1", bus_if.arb_gnt_o); end
    tick();
    n_vec++; if (outstanding !== 3'd4) begin n_err++; $display("FAIL refill_outstanding got %0d exp 4", outstanding); end
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 2'd0, 1'b0, 1'b1, $urandom, 1'b0);
      tick();
    end
    n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL drain_outstanding got %0d exp 0", outstanding); end
    for (int k = 0; k <= 10; k++) begin
      apply((k < 10), 2'($urandom_range(3, 0)), 1'b1, (k > 0), $urandom, 1'b0);
      tick();
    end
    n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL wrap_outstanding got %0d exp 0", outstanding); end
  endtask

  task automatic test_unexpected();
    apply(1'b0, 2'd0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    tick();
    n_vec++; if (rsp_err !== 1'b1) begin n_err++; $display("FAIL unexp_err got %b exp 1", rsp_err); end
    n_vec++; if (bus_if.rsp_valid_o !== 4'b0000) begin n_err++; $display("FAIL unexp_valid got %b exp 0000", bus_if.rsp_valid_o); end
    n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL unexp_outstanding got %0d exp 0", outstanding); end
    apply(1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL unexp_pulse got %b exp 0", rsp_err); end
  endtask

  task automatic test_flush();
    apply(1'b1, 2'd1, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    apply(1'b1, 2'd2, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    n_vec++; if (outstanding !== 3'd2) begin n_err++; $display("FAIL flush_pre got %0d exp 2", outstanding); end
    apply(1'b1, 2'd3, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL flush_outstanding got %0d exp 0", outstanding); end
    flush = 1'b0;
    apply(1'b0, 2'd0, 1'b0, 1'b1, 32'h5555_AAAA, 1'b0);
    tick();
    n_vec++; if (rsp_err !== 1'b1) begin n_err++; $display("FAIL flush_late_err got %b exp 1", rsp_err); end
    n_vec++; if (bus_if.rsp_valid_o !== 4'b0000) begin n_err++; $display("FAIL flush_late_valid got %b exp 0000", bus_if.rsp_valid_o); end
    apply(1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_mid_reset();
    apply(1'b1, 2'd3, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    apply(1'b1, 2'd0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    bus_if.arb_req_i = 1'b0; bus_if.mem_gnt_i = 1'b0;
    rst = 1'b1;
    model_q.delete();
    last_data = 32'h0;
    tick();
    rst = 1'b0;
    n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL midrst_outstanding got %0d exp 0", outstanding); end
    n_vec++; if (bus_if.rsp_data_o !== 32'h0) begin n_err++; $display("FAIL midrst_data got %h exp 0", bus_if.rsp_data_o); end
    apply(1'b0, 2'd0, 1'b0, 1'b1, 32'h0BAD_0BAD, 1'b0);
    tick();
    n_vec++; if (rsp_err !== 1'b1) begin n_err++; $display("FAIL midrst_err got %b exp 1", rsp_err); end
    apply(1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_routing();
    test_fill();
    test_full_pop_and_wrap();
    test_unexpected();
    test_flush();
    test_mid_reset();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover got %0d exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
